// File: rtl/s2p_pkg.sv
// s2p_pkg: shared definitions for the serial-to-parallel deserializer.
//   s2p_state_t       - FSM state encoding (IDLE, SHIFT)
//   S2P_DEFAULT_WIDTH - default word length in bits
package s2p_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } s2p_state_t;

  localparam int S2P_DEFAULT_WIDTH = 4;

endpackage

// File: rtl/s2p_hold_reg.sv
// s2p_hold_reg: WIDTH-bit output holding register with a valid/ready
// handshake and overrun detection.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         a freshly assembled word is available this cycle
//   word         the freshly assembled word
//   dout         holding register contents
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accepts dout when high together with dout_valid
//   overrun      registered one-cycle pulse: an unconsumed word was overwritten
module s2p_hold_reg
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun
);

  // The newest word always wins. A word that arrives while the old one is
  // still valid and not being taken this cycle is reported as an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load & dout_valid & ~dout_ready;
      if (load) begin
        dout       <= word;
        dout_valid <= 1'b1;
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial2parallel.sv
// serial2parallel: reassembles an MSB-first serial bit stream, framed by a
// start-of-frame strobe, into WIDTH-bit words on a valid/ready interface.
// Optional feature macro: S2P_FRAME_CHECK_EN - a start-of-frame seen in the
// middle of a word discards the partial word, resynchronises on the new
// frame and pulses frame_err. Without it, frame_err is tied 0.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   din          serial data, MSB first
//   sof          high with bit WIDTH-1 of a new word
//   dout         assembled word (holding register)
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accept
//   overrun      one-cycle pulse: an unconsumed word was overwritten
//   frame_err    one-cycle pulse: premature sof (frame-check build only)
//   busy         FSM is in SHIFT
module serial2parallel
  import s2p_pkg::*;
#(
  parameter int WIDTH = S2P_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  output logic             frame_err,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  s2p_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-2:0] shreg, shreg_next;
  logic [WIDTH-1:0] shifted;
  logic             load;
  logic             resync;

  // Shift register concatenated with the current bit: its low WIDTH-1 bits
  // are the next shift-register value, and in the completion cycle the
  // whole vector is the finished word.
  assign shifted = {shreg, din};

  // State, bit counter and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shreg <= shreg_next;
    end
  end

  // Next-state logic. Every cycle in SHIFT takes a bit; the first bit is
  // taken in IDLE together with sof, so cnt counts bits already captured.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    load       = 1'b0;
    resync     = 1'b0;
    case (state)
      IDLE: begin
        if (sof) begin
          shreg_next = shifted[WIDTH-2:0];
          cnt_next   = CNT_ONE;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
`ifdef S2P_FRAME_CHECK_EN
        resync = sof;
`endif
        shreg_next = shifted[WIDTH-2:0];
        if (resync) begin
          // Current bit becomes the MSB of a new frame; the partial word is dropped.
          cnt_next = CNT_ONE;
        end else if (cnt == CNT_LAST) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef S2P_FRAME_CHECK_EN
  // Registered so the pulse lands in the cycle after the premature sof.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= resync;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

  assign busy = (state == SHIFT);

  s2p_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .word      (shifted),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .overrun   (overrun)
  );

endmodule
